// File: rtl/hdcpu_pkg.sv
// rtl/hdcpu_pkg.sv - shared beat-state, beat encoding and console mode definitions
package hdcpu_pkg;

    localparam int SW_W = 3;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } beat_t;

    localparam logic [2:0] W_HALT = 3'b000;
    localparam logic [2:0] W_B1   = 3'b001;
    localparam logic [2:0] W_B2   = 3'b010;
    localparam logic [2:0] W_B3   = 3'b100;

    localparam logic [SW_W-1:0] SW_EXEC    = 3'b000;
    localparam logic [SW_W-1:0] SW_WR_MEM  = 3'b001;
    localparam logic [SW_W-1:0] SW_RD_MEM  = 3'b010;
    localparam logic [SW_W-1:0] SW_RD_REG  = 3'b011;
    localparam logic [SW_W-1:0] SW_WR_REG  = 3'b100;

    function automatic logic [2:0] beat_to_w(input beat_t beat);
        case (beat)
            B1:      beat_to_w = W_B1;
            B2:      beat_to_w = W_B2;
            B3:      beat_to_w = W_B3;
            default: beat_to_w = W_HALT;
        endcase
    endfunction

endpackage

// File: rtl/beat_timing_ctrl_if.sv
// rtl/beat_timing_ctrl_if.sv - console/decoder to beat sequencer signal bundle
interface beat_timing_ctrl_if
    import hdcpu_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             QD;
    logic             DP;
    logic [SW_W-1:0]  SW;
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic             SST0;
    logic [2:0]       W;
    logic             ST0;
    logic             RUN;
    logic             CYC_END;
    logic [CNT_W-1:0] CYC_CNT;

    modport master (
        output QD, DP, SW, SHORT, LONG, STOP, SST0,
        input  W, ST0, RUN, CYC_END, CYC_CNT
    );

    modport slave (
        input  QD, DP, SW, SHORT, LONG, STOP, SST0,
        output W, ST0, RUN, CYC_END, CYC_CNT
    );
endinterface

// File: rtl/hdcpu_sync.sv
// rtl/hdcpu_sync.sv - multi-flop synchroniser for asynchronous console inputs
module hdcpu_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [STAGES-1:0][WIDTH-1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/beat_timing_ctrl.sv
// rtl/beat_timing_ctrl.sv - machine beat sequencer producing W[3:1], ST0 and cycle bookkeeping
module beat_timing_ctrl
    import hdcpu_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               T3,
    input  logic               CLR,
    beat_timing_ctrl_if.slave  bus
);
    logic            w_qd_s;
    logic            w_dp_s;
    logic [SW_W-1:0] w_sw_s;

    hdcpu_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_qd (
        .clk(T3), .rst_n(CLR), .i_d(bus.QD), .o_q(w_qd_s)
    );
    hdcpu_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_dp (
        .clk(T3), .rst_n(CLR), .i_d(bus.DP), .o_q(w_dp_s)
    );
    hdcpu_sync #(.WIDTH(SW_W), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clk(T3), .rst_n(CLR), .i_d(bus.SW), .o_q(w_sw_s)
    );

    beat_t            r_state, w_state_n;
    beat_t            r_pend, w_pend_n;
    logic             r_st0, w_st0_n;
    logic             r_cyc_end, w_cyc_end_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [SW_W-1:0]  r_sw_q, w_sw_q_n;
    logic             r_qd_prev;

    logic  w_qd_rise;
    beat_t w_beat_next;
    logic  w_cyc_done;

    assign w_qd_rise = w_qd_s & ~r_qd_prev;

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            r_state   <= HALT;
            r_pend    <= B1;
            r_st0     <= 1'b0;
            r_cyc_end <= 1'b0;
            r_cnt     <= '0;
            r_sw_q    <= '0;
            r_qd_prev <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pend    <= w_pend_n;
            r_st0     <= w_st0_n;
            r_cyc_end <= w_cyc_end_n;
            r_cnt     <= w_cnt_n;
            r_sw_q    <= w_sw_q_n;
            r_qd_prev <= w_qd_s;
        end
    end

    // Beat the running sequence would take next, and whether that edge closes a machine cycle.
    always_comb begin
        w_beat_next = B1;
        w_cyc_done  = 1'b0;
        case (r_state)
            B1: begin
                if (bus.SHORT) begin
                    w_beat_next = B1;
                    w_cyc_done  = 1'b1;
                end else begin
                    w_beat_next = B2;
                end
            end
            B2: begin
                if (bus.LONG) begin
                    w_beat_next = B3;
                end else begin
                    w_beat_next = B1;
                    w_cyc_done  = 1'b1;
                end
            end
            B3: begin
                w_beat_next = B1;
                w_cyc_done  = 1'b1;
            end
            default: begin
                w_beat_next = B1;
                w_cyc_done  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_n   = r_state;
        w_pend_n    = r_pend;
        w_st0_n     = r_st0;
        w_cyc_end_n = 1'b0;
        w_cnt_n     = r_cnt;
        w_sw_q_n    = r_sw_q;

        if (w_sw_s != r_sw_q) begin
            // A console mode change abandons everything in flight.
            w_sw_q_n  = w_sw_s;
            w_state_n = HALT;
            w_pend_n  = B1;
            w_st0_n   = 1'b0;
            w_cnt_n   = '0;
        end else if (r_state == HALT) begin
            if (w_qd_rise) begin
                w_state_n = r_pend;
            end
        end else begin
            if (bus.SST0) begin
                w_st0_n = 1'b1;
            end
            if (w_cyc_done) begin
                w_cyc_end_n = 1'b1;
                w_cnt_n     = r_cnt + 1'b1;
            end
            if (w_cyc_done && w_dp_s) begin
                w_pend_n  = B1;
                w_state_n = HALT;
            end else if (bus.STOP) begin
                w_pend_n  = w_beat_next;
                w_state_n = HALT;
            end else begin
                w_state_n = w_beat_next;
            end
        end
    end

    assign bus.W       = beat_to_w(r_state);
    assign bus.RUN     = (r_state != HALT);
    assign bus.ST0     = r_st0;
    assign bus.CYC_END = r_cyc_end;
    assign bus.CYC_CNT = r_cnt;
endmodule

// File: tb/tb_beat_timing_ctrl.sv
// tb/tb_beat_timing_ctrl.sv - directed self-checking bench for beat_timing_ctrl
module tb_beat_timing_ctrl;
    localparam int CNT_W = 2;
    localparam int SS    = 2;

    logic T3  = 1'b0;
    logic CLR = 1'b0;

    beat_timing_ctrl_if #(.CNT_W(CNT_W)) bus ();

    beat_timing_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .T3  (T3),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 T3 = ~T3;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic step();
        @(posedge T3);
        #1;
    endtask

    task automatic clear_inputs();
        bus.QD    = 1'b0;
        bus.DP    = 1'b0;
        bus.SW    = 3'b000;
        bus.SHORT = 1'b0;
        bus.LONG  = 1'b0;
        bus.STOP  = 1'b0;
        bus.SST0  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        CLR = 1'b0;
        step();
        step();
        CLR = 1'b1;
        repeat (3) step();
    endtask

    task automatic press_qd();
        bus.QD = 1'b1;
        repeat (SS + 1) step();
    endtask

    task automatic test_reset();
        clear_inputs();
        CLR = 1'b0;
        step();
        step();
        n_checks++; if (bus.W !== 3'b000) $display("FAIL reset_w: got %b want 000", bus.W); else n_pass++;
        n_checks++; if (bus.ST0 !== 1'b0) $display("FAIL reset_st0: got %b want 0", bus.ST0); else n_pass++;
        n_checks++; if (bus.RUN !== 1'b0) $display("FAIL reset_run: got %b want 0", bus.RUN); else n_pass++;
        n_checks++; if (bus.CYC_END !== 1'b0) $display("FAIL reset_cyc_end: got %b want 0", bus.CYC_END); else n_pass++;
        n_checks++; if (bus.CYC_CNT !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", bus.CYC_CNT); else n_pass++;
        CLR = 1'b1;
        repeat (3) step();
        n_checks++; if (bus.W !== 3'b000) $display("FAIL reset_no_resume: got %b want 000", bus.W); else n_pass++;
    endtask

    task automatic test_short();
        do_reset();
        bus.SHORT = 1'b1;
        n_checks++; if (bus.W !== 3'b000) $display("FAIL short_w0: got %b want 000", bus.W); else n_pass++;
        press_qd();
        bus.QD = 1'b0;
        n_checks++; if (bus.W !== 3'b001) $display("FAIL short_start: got %b want 001", bus.W); else n_pass++;
        n_checks++; if (bus.CYC_END !== 1'b0) $display("FAIL short_start_end: got %b want 0", bus.CYC_END); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (bus.W !== 3'b001) $display("FAIL short_w%0d: got %b want 001", i, bus.W); else n_pass++;
            n_checks++; if (bus.CYC_END !== 1'b1) $display("FAIL short_end%0d: got %b want 1", i, bus.CYC_END); else n_pass++;
            n_checks++; if (bus.CYC_CNT !== CNT_W'(i)) $display("FAIL short_cnt%0d: got %0d want %0d", i, bus.CYC_CNT, i); else n_pass++;
        end
    endtask

    task automatic test_long();
        logic [2:0] exp_w [5];
        logic       exp_e [5];
        exp_w = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b001};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.LONG = 1'b1;
        press_qd();
        bus.QD = 1'b0;
        n_checks++; if (bus.W !== 3'b001) $display("FAIL long_start: got %b want 001", bus.W); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) bus.LONG = 1'b0;
            step();
            n_checks++; if (bus.W !== exp_w[i]) $display("FAIL long_w%0d: got %b want %b", i, bus.W, exp_w[i]); else n_pass++;
            n_checks++; if (bus.CYC_END !== exp_e[i]) $display("FAIL long_end%0d: got %b want %b", i, bus.CYC_END, exp_e[i]); else n_pass++;
        end
        n_checks++; if (bus.CYC_CNT !== 2'd2) $display("FAIL long_cnt: got %0d want 2", bus.CYC_CNT); else n_pass++;
    endtask

    task automatic test_stop();
        do_reset();
        press_qd();
        n_checks++; if (bus.W !== 3'b001) $display("FAIL stop_start: got %b want 001", bus.W); else n_pass++;
        bus.STOP = 1'b1;
        step();
        bus.STOP = 1'b0;
        n_checks++; if (bus.W !== 3'b000) $display("FAIL stop_w: got %b want 000", bus.W); else n_pass++;
        n_checks++; if (bus.RUN !== 1'b0) $display("FAIL stop_run: got %b want 0", bus.RUN); else n_pass++;
        n_checks++; if (bus.CYC_END !== 1'b0) $display("FAIL stop_end: got %b want 0", bus.CYC_END); else n_pass++;
        repeat (5) step();
        n_checks++; if (bus.W !== 3'b000) $display("FAIL stop_held_qd: got %b want 000", bus.W); else n_pass++;
        bus.QD = 1'b0;
        repeat (SS + 1) step();
        press_qd();
        bus.QD = 1'b0;
        n_checks++; if (bus.W !== 3'b010) $display("FAIL stop_resume: got %b want 010", bus.W); else n_pass++;
        step();
        n_checks++; if (bus.W !== 3'b001) $display("FAIL stop_after_w: got %b want 001", bus.W); else n_pass++;
        n_checks++; if (bus.CYC_END !== 1'b1) $display("FAIL stop_after_end: got %b want 1", bus.CYC_END); else n_pass++;
    endtask

    task automatic test_single_step();
        do_reset();
        bus.DP    = 1'b1;
        bus.SHORT = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            press_qd();
            bus.QD = 1'b0;
            n_checks++; if (bus.W !== 3'b001) $display("FAIL ss_beat%0d: got %b want 001", k, bus.W); else n_pass++;
            step();
            n_checks++; if (bus.W !== 3'b000) $display("FAIL ss_halt%0d: got %b want 000", k, bus.W); else n_pass++;
            n_checks++; if (bus.CYC_END !== 1'b1) $display("FAIL ss_end%0d: got %b want 1", k, bus.CYC_END); else n_pass++;
            n_checks++; if (bus.CYC_CNT !== CNT_W'(k)) $display("FAIL ss_cnt%0d: got %0d want %0d", k, bus.CYC_CNT, k); else n_pass++;
            step();
            n_checks++; if (bus.W !== 3'b000) $display("FAIL ss_stay%0d: got %b want 000", k, bus.W); else n_pass++;
            n_checks++; if (bus.CYC_END !== 1'b0) $display("FAIL ss_end_clr%0d: got %b want 0", k, bus.CYC_END); else n_pass++;
            step();
        end
        bus.DP = 1'b0;
    endtask

    task automatic test_st0_sw();
        do_reset();
        bus.SW = 3'b001;
        repeat (4) step();
        n_checks++; if (bus.W !== 3'b000) $display("FAIL sw_settle: got %b want 000", bus.W); else n_pass++;
        press_qd();
        bus.QD   = 1'b0;
        bus.SST0 = 1'b1;
        step();
        bus.SST0 = 1'b0;
        n_checks++; if (bus.ST0 !== 1'b1) $display("FAIL st0_set: got %b want 1", bus.ST0); else n_pass++;
        n_checks++; if (bus.W !== 3'b010) $display("FAIL st0_w: got %b want 010", bus.W); else n_pass++;
        repeat (3) step();
        n_checks++; if (bus.ST0 !== 1'b1) $display("FAIL st0_hold: got %b want 1", bus.ST0); else n_pass++;
        n_checks++; if (bus.CYC_CNT !== 2'd2) $display("FAIL st0_cnt: got %0d want 2", bus.CYC_CNT); else n_pass++;
        bus.SW = 3'b010;
        repeat (SS) step();
        n_checks++; if (bus.ST0 !== 1'b1) $display("FAIL sw_pre_st0: got %b want 1", bus.ST0); else n_pass++;
        n_checks++; if (bus.W !== 3'b001) $display("FAIL sw_pre_w: got %b want 001", bus.W); else n_pass++;
        n_checks++; if (bus.CYC_CNT !== 2'd3) $display("FAIL sw_pre_cnt: got %0d want 3", bus.CYC_CNT); else n_pass++;
        step();
        n_checks++; if (bus.ST0 !== 1'b0) $display("FAIL sw_st0: got %b want 0", bus.ST0); else n_pass++;
        n_checks++; if (bus.W !== 3'b000) $display("FAIL sw_w: got %b want 000", bus.W); else n_pass++;
        n_checks++; if (bus.CYC_CNT !== 2'd0) $display("FAIL sw_cnt: got %0d want 0", bus.CYC_CNT); else n_pass++;
        n_checks++; if (bus.RUN !== 1'b0) $display("FAIL sw_run: got %b want 0", bus.RUN); else n_pass++;
    endtask

    task automatic test_wrap_async_clr();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        bus.SHORT = 1'b1;
        bus.SST0  = 1'b1;
        press_qd();
        bus.QD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (bus.CYC_CNT !== exp_cnt[i]) $display("FAIL wrap_cnt%0d: got %0d want %0d", i, bus.CYC_CNT, exp_cnt[i]); else n_pass++;
        end
        bus.SHORT = 1'b0;
        step();
        n_checks++; if (bus.W !== 3'b010) $display("FAIL clr_pre_w: got %b want 010", bus.W); else n_pass++;
        n_checks++; if (bus.ST0 !== 1'b1) $display("FAIL clr_pre_st0: got %b want 1", bus.ST0); else n_pass++;
        #3;
        CLR = 1'b0;
        #1;
        n_checks++; if (bus.W !== 3'b000) $display("FAIL clr_async_w: got %b want 000", bus.W); else n_pass++;
        n_checks++; if (bus.ST0 !== 1'b0) $display("FAIL clr_async_st0: got %b want 0", bus.ST0); else n_pass++;
        n_checks++; if (bus.RUN !== 1'b0) $display("FAIL clr_async_run: got %b want 0", bus.RUN); else n_pass++;
        n_checks++; if (bus.CYC_CNT !== 2'd0) $display("FAIL clr_async_cnt: got %0d want 0", bus.CYC_CNT); else n_pass++;
        #1;
        CLR = 1'b1;
        bus.SST0 = 1'b0;
        repeat (5) step();
        n_checks++; if (bus.W !== 3'b000) $display("FAIL clr_no_resume: got %b want 000", bus.W); else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_short();
        test_long();
        test_stop();
        test_single_step();
        test_st0_sw();
        test_wrap_async_clr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
